// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one IM read at a time, holds the word for IF/ID.
// Optional performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_CPU,
  input  logic        jb,
  input  logic [31:0] jb_target,
  output logic        im_req_valid,
  input  logic        im_req_ready,
  output logic [31:0] im_req_addr,
  input  logic        im_rsp_valid,
  input  logic [31:0] im_rsp_data,
  output logic [31:0] F_pc_out,
  output logic [31:0] F_inst_out,
  output logic        F_inst_valid,
  output logic        stall_AXI,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_kill_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        redir_pend_q;
  logic [31:0] redir_pc_q;
  logic        kill_q;
  logic [31:0] held_inst_q;

  logic        take_jb;
  logic [31:0] jb_tgt_al;
  logic        redir_d;
  logic [31:0] redir_pc_d;
  logic        discard_d;

  assign take_jb   = jb & ~stall_CPU;
  assign jb_tgt_al = {jb_target[31:2], 2'b00};
  // A redirect arriving in the same cycle as the response still wins over the stored one.
  assign redir_d    = kill_q | redir_pend_q | take_jb;
  assign redir_pc_d = take_jb ? jb_tgt_al : redir_pc_q;
  assign discard_d  = (state_q == WAIT) & im_rsp_valid & redir_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      kill_q       <= 1'b0;
      held_inst_q  <= NOP_INST;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: begin
          if (take_jb) begin
            redir_pend_q <= 1'b1;
            kill_q       <= 1'b1;
            redir_pc_q   <= jb_tgt_al;
          end
          if (im_req_ready) state_q <= WAIT;
        end
        WAIT: begin
          if (im_rsp_valid) begin
            if (redir_d) begin
              pc_q         <= redir_pc_d;
              redir_pend_q <= 1'b0;
              kill_q       <= 1'b0;
              state_q      <= REQ;
            end else begin
              held_inst_q <= im_rsp_data;
              state_q     <= DONE;
            end
          end else if (take_jb) begin
            redir_pend_q <= 1'b1;
            kill_q       <= 1'b1;
            redir_pc_q   <= jb_tgt_al;
          end
        end
        DONE: begin
          if (!stall_CPU) begin
            pc_q        <= jb ? jb_tgt_al : pc_q + 32'd4;
            held_inst_q <= NOP_INST;
            state_q     <= REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign im_req_valid = (state_q == REQ);
  assign im_req_addr  = pc_q;
  assign F_pc_out     = pc_q;
  assign F_inst_valid = (state_q == DONE);
  assign F_inst_out   = (state_q == DONE) ? held_inst_q : NOP_INST;
  assign stall_AXI    = (state_q != DONE) | redir_pend_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] kill_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      if (stall_AXI && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (discard_d && kill_cnt_q != '1)  kill_cnt_q  <= kill_cnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_kill_cnt  = kill_cnt_q;
`else
  logic unused_perf;
  assign unused_perf    = discard_d;
  assign perf_stall_cnt = '0;
  assign perf_kill_cnt  = '0;
`endif

`ifndef SYNTHESIS
  // Responses before the first accept since reset are late replies to a pre-reset request.
  logic acc_seen_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_seen_q <= 1'b0;
    end else begin
      if (state_q == REQ && im_req_ready) acc_seen_q <= 1'b1;
      assert (!(im_rsp_valid && state_q != WAIT && acc_seen_q));
      assert (!(state_q == DONE && redir_pend_q));
    end
  end
`endif

endmodule
